// File: rtl/datapath_driver_pkg.sv
// Shared types and constants for the datapath driver and its response FIFO.
package dp_drv_pkg;

  localparam int DP_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage : dp_drv_pkg

// File: rtl/datapath_driver_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding datapath results until the
// response port consumes them. The head entry is always visible on head_data.
module dp_rsp_fifo
  import dp_drv_pkg::*;
#(
  parameter int WIDTH = DP_W,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok_s;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok_s = pop & (count_q != {CW{1'b0}});

    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset discards all stored results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule : dp_rsp_fifo

// File: rtl/datapath_driver.sv
// Request initiator / result collector for the 16-bit datapath unit. Issues
// operand and coefficient with the datapath's pipeline alignment, tracks
// in-flight operations with a tag shifter, collects results into a response
// FIFO and only grants requests when a FIFO slot is guaranteed.
module datapath_driver
  import dp_drv_pkg::*;
#(
  parameter int WIDTH      = DP_W,
  parameter int DP_LATENCY = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_coeff,
  output logic [WIDTH-1:0] dp_data_in,
  output logic [WIDTH-1:0] dp_coeff,
  output logic             dp_load,
  output logic             dp_compute,
  input  logic [WIDTH-1:0] dp_data_out,
  input  logic             dp_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             err_valid
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int IW = $clog2(DP_LATENCY + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  state_e           state_q, state_d;
  logic [DP_LATENCY-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] data_hold_q, data_hold_d;
  logic [WIDTH-1:0] coeff_q, coeff_d;
  logic             err_q, err_d;

  logic [IW-1:0]    inflight_s;
  logic [CW-1:0]    fifo_count_s;
  logic [SW-1:0]    credit_sum_s;
  logic             fifo_empty_s;
  logic             req_ready_s;
  logic             issue_s;
  logic             compute_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] head_data_s;

  // Count of operations currently travelling through the datapath.
  always_comb begin
    inflight_s = {IW{1'b0}};
    for (int i = 0; i < DP_LATENCY; i++) begin
      inflight_s = inflight_s + IW'(tag_q[i]);
    end
  end

  // Credit check: every granted request must already own a FIFO slot, so a
  // result arriving from the datapath can always be stored.
  always_comb begin
    fifo_empty_s = (fifo_count_s == {CW{1'b0}});
    credit_sum_s = SW'(fifo_count_s) + SW'(inflight_s);
    if (rst) begin
      req_ready_s = 1'b0;
    end else begin
      req_ready_s = en & (state_q != DRAIN) & (credit_sum_s < SW'(RSP_DEPTH));
    end
    issue_s   = req_valid & req_ready_s;
    compute_s = (inflight_s != {IW{1'b0}}) & ~issue_s;
    push_s    = tag_q[DP_LATENCY-1];
    pop_s     = ~fifo_empty_s & rsp_ready;
  end

  // Datapath pin values: operand with the issue, coefficient one stage later,
  // both held between issues; tags advance one stage per cycle.
  always_comb begin
    data_hold_d = data_hold_q;
    coeff_d     = coeff_q;
    tag_d       = {DP_LATENCY{1'b0}};
    if (issue_s) begin
      data_hold_d = req_data;
      coeff_d     = req_coeff;
    end else begin
      data_hold_d = data_hold_q;
      coeff_d     = coeff_q;
    end
    tag_d[0] = issue_s;
    for (int i = 1; i < DP_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Sticky error: the datapath's valid must match compute without a load.
  always_comb begin
    if (dp_valid != (compute_s & ~issue_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Control FSM next state; a drain always completes through IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue_s) begin
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (~en && ((inflight_s != {IW{1'b0}}) || ~fifo_empty_s)) begin
          state_d = DRAIN;
        end else if ((inflight_s == {IW{1'b0}}) && fifo_empty_s && ~issue_s) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      DRAIN: begin
        if ((inflight_s == {IW{1'b0}}) && fifo_empty_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= {DP_LATENCY{1'b0}};
      data_hold_q <= {WIDTH{1'b0}};
      coeff_q     <= {WIDTH{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      data_hold_q <= data_hold_d;
      coeff_q     <= coeff_d;
      err_q       <= err_d;
    end
  end

  dp_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (dp_data_out),
    .pop       (pop_s),
    .head_data (head_data_s),
    .count     (fifo_count_s)
  );

  assign req_ready  = req_ready_s;
  assign dp_data_in = issue_s ? req_data : data_hold_q;
  assign dp_coeff   = coeff_q;
  assign dp_load    = issue_s;
  assign dp_compute = compute_s;
  assign rsp_valid  = ~fifo_empty_s;
  assign rsp_data   = head_data_s;
  assign busy       = (state_q != IDLE);
  assign err_valid  = err_q;

endmodule : datapath_driver

// File: tb/tb_datapath_driver.sv
// Bench for datapath_driver: a behavioural datapath stand-in plus a queue-based
// reference of expected results in request order.
module tb_datapath_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_data;
  logic [15:0] req_coeff;
  logic [15:0] dp_data_in;
  logic [15:0] dp_coeff;
  logic        dp_load;
  logic        dp_compute;
  logic [15:0] dp_data_out;
  logic        dp_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        busy;
  logic        err_valid;

  logic        force_bad;
  int          vectors = 0;
  int          miscompares = 0;
  int          rsp_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  datapath_driver dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_coeff(req_coeff),
    .dp_data_in(dp_data_in), .dp_coeff(dp_coeff),
    .dp_load(dp_load), .dp_compute(dp_compute),
    .dp_data_out(dp_data_out), .dp_valid(dp_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .err_valid(err_valid)
  );

  // Datapath transfer function used by both the stand-in and the reference.
  function automatic logic [15:0] dp_fn(input logic [15:0] d, input logic [15:0] c);
    logic [31:0] p;
    p = d * c;
    return p[15:0] ^ {c[7:0], c[15:8]};
  endfunction

  // Datapath stand-in: captures data on load, coefficient one cycle later,
  // result visible the cycle after that.
  logic        dpm_s1_v = 1'b0;
  logic [15:0] dpm_s1_d = 16'h0000;
  logic [15:0] dpm_out  = 16'h0000;
  always @(posedge clk) begin
    dpm_s1_v <= dp_load;
    if (dp_load) dpm_s1_d <= dp_data_in;
    if (dpm_s1_v) dpm_out <= dp_fn(dpm_s1_d, dp_coeff);
  end
  assign dp_data_out = dpm_out;
  assign dp_valid    = force_bad ? 1'b0 : (dp_compute & ~dp_load);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference scoreboard: record accepted requests, check responses in order.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (req_valid && req_ready) exp_q.push_back(dp_fn(req_data, req_coeff));
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc, first, last, base, bad;
    logic seen;
    rst = 1'b1; en = 1'b1; req_valid = 1'b0; req_data = 16'h0000;
    req_coeff = 16'h0000; rsp_ready = 1'b1; force_bad = 1'b0;

    // Reset state
    repeat (2) smp;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_valid), 32'd0);
    chk("rst_load", 32'(dp_load), 32'd0);
    chk("rst_compute", 32'(dp_compute), 32'd0);
    chk("rst_data_in", 32'(dp_data_in), 32'd0);
    chk("rst_coeff", 32'(dp_coeff), 32'd0);
    step; rst = 1'b0;

    // 1. Single op alignment
    step; req_valid = 1'b1; req_data = 16'h00FF; req_coeff = 16'h0F0F;
    smp;
    chk("t1_ready", 32'(req_ready), 32'd1);
    chk("t1_load", 32'(dp_load), 32'd1);
    chk("t1_data_in", 32'(dp_data_in), 32'h00FF);
    step; req_valid = 1'b0; req_data = 16'hABCD; req_coeff = 16'h1234;
    smp;
    chk("t1_coeff", 32'(dp_coeff), 32'h0F0F);
    chk("t1_load_off", 32'(dp_load), 32'd0);
    chk("t1_data_hold", 32'(dp_data_in), 32'h00FF);
    chk("t1_compute1", 32'(dp_compute), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rsp_t1", 32'(rsp_valid), 32'd0);
    step; smp;
    chk("t1_rsp_t2", 32'(rsp_valid), 32'd0);
    chk("t1_compute2", 32'(dp_compute), 32'd1);
    step; smp;
    chk("t1_rsp_t3", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data", 32'(rsp_data), 32'(dp_fn(16'h00FF, 16'h0F0F)));
    wait_idle("t1_idle");

    // 2. Eight back-to-back requests at full rate
    first = -1; last = -1;
    for (int i = 0; i < 14; i++) begin
      step;
      req_valid = (i < 8);
      req_data = 16'($urandom); req_coeff = 16'($urandom);
      smp;
      if (i < 8) chk("t2_ready", 32'(req_ready), 32'd1);
      if (rsp_valid) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("t2_first_rsp", 32'(first), 32'd3);
    chk("t2_last_rsp", 32'(last), 32'd10);
    wait_idle("t2_idle");

    // 3. Backpressure: exactly RSP_DEPTH accepted, then resume
    rsp_ready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      step; req_valid = 1'b1; req_data = 16'($urandom); req_coeff = 16'($urandom);
      smp;
      if (req_ready) acc++;
    end
    chk("t3_accepted", 32'(acc), 32'd4);
    chk("t3_ready_low", 32'(req_ready), 32'd0);
    step; rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      smp;
      if (req_ready) seen = 1'b1;
      else step;
    end
    chk("t3_resume", 32'(seen), 32'd1);
    step; req_valid = 1'b0;
    wait_idle("t3_idle");

    // Randomized traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      step;
      req_valid = 1'($urandom_range(0, 1));
      req_data = 16'($urandom); req_coeff = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    step; req_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle("rand_idle");
    chk("rand_err", 32'(err_valid), 32'd0);

    // 4. Drop en with two in flight
    base = rsp_cnt;
    step; req_valid = 1'b1; req_data = 16'($urandom); req_coeff = 16'($urandom);
    step; req_data = 16'($urandom); req_coeff = 16'($urandom);
    step; req_valid = 1'b0; en = 1'b0;
    smp;
    chk("t4_busy", 32'(busy), 32'd1);
    step; en = 1'b1;
    for (int i = 0; i < 20 && busy; i++) begin
      smp; #1;
      if (busy) chk("t4_drain_ready", 32'(req_ready), 32'd0);
    end
    chk("t4_rsp_count", 32'(rsp_cnt - base), 32'd2);
    chk("t4_idle", 32'(busy), 32'd0);

    // 6. dp_valid disagrees with compute -> sticky error
    step; req_valid = 1'b1; req_data = 16'($urandom); req_coeff = 16'($urandom);
    step; req_valid = 1'b0; force_bad = 1'b1;
    smp;
    chk("t6_compute", 32'(dp_compute), 32'd1);
    chk("t6_err_before", 32'(err_valid), 32'd0);
    step; force_bad = 1'b0;
    smp;
    chk("t6_err_set", 32'(err_valid), 32'd1);
    wait_idle("t6_idle");
    chk("t6_err_sticky", 32'(err_valid), 32'd1);

    // 5. Asynchronous reset with three results buffered
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step; req_valid = 1'b1; req_data = 16'($urandom); req_coeff = 16'($urandom);
    end
    step; req_valid = 1'b0;
    repeat (4) step;
    smp;
    chk("t5_buffered", 32'(rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_err", 32'(err_valid), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd0);
    chk("t5_rsp_data", 32'(rsp_data), 32'd0);
    rsp_ready = 1'b1;
    step; step; rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      smp;
      if (rsp_valid) bad++;
    end
    chk("t5_no_rsp", 32'(bad), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_datapath_driver
